// File: rtl/fifo_modport_pkg.sv
// Shared constants and types for the fifo_modport slice.
// Default geometry: 16 words of 8 bits.
package fifo_modport_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef logic [DEF_ADDR_WIDTH:0]   ptr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_modport_mem.sv
// Dual-port RAM for fifo_modport.
// Synchronous write, asynchronous read address.
module fifo_modport_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_modport.sv
// Single-clock FIFO with wrap-bit pointers and registered read data.
// Define FIFO_OVERFLOW_FLAGS_EN for sticky o_overflow/o_underflow outputs.
module fifo_modport
    import fifo_modport_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_winc,
    output logic                  o_wfull,
    input  logic                  i_rinc,
    output logic [DATA_WIDTH-1:0] o_rdata,
`ifdef FIFO_OVERFLOW_FLAGS_EN
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic                  o_rempty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  w_acc;
    logic                  r_acc;

    assign o_rempty = (wptr == rptr);
    assign o_wfull  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                      (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    // Flags come from registered pointers, so full/empty gate this edge
    assign w_acc = i_winc && !o_wfull;
    assign r_acc = i_rinc && !o_rempty;

    fifo_modport_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (i_clk),
        .we    (w_acc),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (i_wdata),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            o_rdata <= '0;
        end else begin
            if (w_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (r_acc) begin
                rptr    <= rptr + PTR_ONE;
                o_rdata <= mem_rdata;
            end
        end
    end

`ifdef FIFO_OVERFLOW_FLAGS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_winc && o_wfull) begin
                o_overflow <= 1'b1;
            end
            if (i_rinc && o_rempty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_modport.sv
// Directed bench for fifo_modport: vector table plus
// hand sequences for fill, wrap, full-concurrency and reset.
module tb_fifo_modport;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic       wfull;
    logic       rempty;
    logic [7:0] rdata;
`ifdef FIFO_OVERFLOW_FLAGS_EN
    logic       ovf;
    logic       unf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_modport dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wdata  (wdata),
        .i_winc   (winc),
        .o_wfull  (wfull),
        .i_rinc   (rinc),
        .o_rdata  (rdata),
`ifdef FIFO_OVERFLOW_FLAGS_EN
        .o_overflow  (ovf),
        .o_underflow (unf),
`endif
        .o_rempty (rempty)
    );

    typedef struct {
        logic       rst_n;
        logic       winc;
        logic [7:0] wdata;
        logic       rinc;
        logic [7:0] exp_rdata;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    vec_t vecs[12];

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply current inputs across one rising edge, settle 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d,
                         input logic rd);
        rst_n = r;
        winc  = w;
        wdata = d;
        rinc  = rd;
        step();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;

        //         rst  w     wdata  r     rdata  emp   full
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'h44, 1'b1, 8'h33, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst_n, vecs[i].winc, vecs[i].wdata, vecs[i].rinc);
            chk8($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            chk1($sformatf("vec%0d empty", i), rempty, vecs[i].exp_empty);
            chk1($sformatf("vec%0d full", i), wfull, vecs[i].exp_full);
        end
`ifdef FIFO_OVERFLOW_FLAGS_EN
        chk1("underflow sticky", unf, 1'b1);
        chk1("overflow clear", ovf, 1'b0);
`endif

        // Fill to 16, then a dropped 17th write
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b0);
            chk1($sformatf("fill%0d full", i), wfull, (i == 15));
        end
        drive(1'b1, 1'b1, 8'hAA, 1'b0);
        chk1("overflow full", wfull, 1'b1);
`ifdef FIFO_OVERFLOW_FLAGS_EN
        chk1("overflow sticky", ovf, 1'b1);
`endif
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1);
            chk8($sformatf("drain%0d rdata", i), rdata, 8'(i));
            chk1($sformatf("drain%0d full", i), wfull, 1'b0);
            chk1($sformatf("drain%0d empty", i), rempty, (i == 15));
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        chk8("post-drain rdata", rdata, 8'h0F);

        // Preload 8, then 40 concurrent cycles across pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 8'h88 + 8'(i), 1'b1);
            chk8($sformatf("conc%0d rdata", i), rdata, 8'h80 + 8'(i));
            chk1($sformatf("conc%0d empty", i), rempty, 1'b0);
            chk1($sformatf("conc%0d full", i), wfull, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1);
            chk8($sformatf("tail%0d rdata", i), rdata, 8'hA8 + 8'(i));
        end
        chk1("tail empty", rempty, 1'b1);

        // Concurrent read/write on a full FIFO drops the write
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0);
        end
        chk1("pre-conc full", wfull, 1'b1);
        drive(1'b1, 1'b1, 8'hEE, 1'b1);
        chk8("fullconc rdata", rdata, 8'h20);
        chk1("fullconc full", wfull, 1'b0);
        chk1("fullconc empty", rempty, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1);
            chk8($sformatf("fulldrain%0d rdata", i), rdata, 8'h20 + 8'(i));
        end
        chk1("fulldrain empty", rempty, 1'b1);

        // Reset with 5 words stored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'h60 + 8'(i), 1'b0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        chk8("midrst pre rdata", rdata, 8'h60);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("midrst empty", rempty, 1'b1);
        chk1("midrst full", wfull, 1'b0);
        chk8("midrst rdata", rdata, 8'h00);
`ifdef FIFO_OVERFLOW_FLAGS_EN
        chk1("midrst overflow", ovf, 1'b0);
        chk1("midrst underflow", unf, 1'b0);
`endif
        drive(1'b1, 1'b1, 8'h5A, 1'b0);
        chk1("post-rst write empty", rempty, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        chk8("post-rst rdata", rdata, 8'h5A);
        chk1("post-rst empty", rempty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_modport.md
Name: fifo_modport

Overview:
- Single-clock, synchronous first-in-first-out buffer with write-increment/read-increment handshakes and full/empty status.
- Sits between a producer and a consumer in the same clock domain, where decoupling of bursty traffic is needed.
- Storage is a dual-port RAM addressed by binary pointers that carry one extra wrap bit.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH = 16 words.

Ports:
- i_clk  input  1  single clock for all logic.
- i_rst_n  input  1  synchronous, active-low reset, sampled on rising i_clk.
- i_wdata  input  DATA_WIDTH  write data.
- i_winc  input  1  write request; push i_wdata this cycle.
- o_wfull  output  1  FIFO holds 2**ADDR_WIDTH words.
- i_rinc  input  1  read request; pop the head word this cycle.
- o_rdata  output  DATA_WIDTH  registered read data.
- o_rempty  output  1  FIFO holds zero words.

Behaviour:
- All state updates on rising i_clk.
- Reset (i_rst_n=0 at a clock edge):
  - wptr=0, rptr=0, o_rdata=0 → o_rempty=1, o_wfull=0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored words.
- Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the RAM; the MSB is the wrap bit.
- Flags are combinational from the registered pointers:
  - o_rempty = (wptr == rptr).
  - o_wfull = (wptr[MSB] != rptr[MSB]) and (wptr low bits == rptr low bits).
- Write is accepted when i_winc=1 and o_wfull=0:
  - mem[wptr low] <= i_wdata; wptr <= wptr+1.
  - A write while full is dropped; memory and pointers are unchanged.
- Read is accepted when i_rinc=1 and o_rempty=0:
  - o_rdata <= mem[rptr low]; rptr <= rptr+1.
  - Read latency is one cycle: data is valid on o_rdata after the edge that accepted the read.
  - A read while empty is ignored; o_rdata holds its previous value and rptr is unchanged.
- Simultaneous accepted read and write:
  - Both pointers advance; occupancy is unchanged.
  - On a full FIFO, the read is accepted and the write is dropped, because full is evaluated before the edge.
  - On an empty FIFO, the write is accepted and the read is ignored; the new word is not bypassed.
- Flags reflect the new occupancy in the cycle after the accepting edge.
- Pointer arithmetic wraps modulo 2**(ADDR_WIDTH+1), with no saturation.
- o_rdata changes only on an accepted read or on reset.

Optional Feature:
- Macro FIFO_OVERFLOW_FLAGS_EN.
- When defined, two extra outputs are present:
  - o_overflow: sticky; set on a cycle with i_winc=1 and o_wfull=1.
  - o_underflow: sticky; set on a cycle with i_rinc=1 and o_rempty=1.
  - Both are cleared only by reset (reset value 0).
- When not defined, these ports and their logic are absent; dropped requests are silent.

Decomposition:
- Package fifo_modport_pkg holds:
  - Default DATA_WIDTH and ADDR_WIDTH constants.
  - Typedef ptr_t: logic [ADDR_WIDTH:0].
  - Typedef data_t: logic [DATA_WIDTH-1:0].
- One sub-module, fifo_modport_mem:
  - Dual-port RAM with a synchronous write port and an asynchronous read-address port.
  - The top level registers o_rdata from it.
- Pointer and flag logic stays in the top level.

Test Plan:
- Reset check: hold i_rst_n=0 for 2 cycles → o_rempty=1, o_wfull=0, o_rdata=0.
- Basic order: write 0x11, 0x22, 0x33, then read 3 times → o_rdata is 0x11, 0x22, 0x33, each one cycle after its read edge; o_rempty=1 afterwards.
- Fill and overflow:
  - Write 0x00..0x0F → o_wfull=1 after the 16th write.
  - A 17th write of 0xAA is dropped.
  - Reading 16 words returns 0x00..0x0F and never 0xAA.
  - With FIFO_OVERFLOW_FLAGS_EN defined, o_overflow=1.
- Underflow: read while empty → o_rdata unchanged, o_rempty stays 1; with the macro defined, o_underflow=1.
- Simultaneous and wrap:
  - Preload 8 words, then do 40 cycles of concurrent write and read with an incrementing pattern.
  - Occupancy stays 8, the flags never toggle, and read data matches the write sequence across pointer wrap.
  - Repeat on a full FIFO: read accepted, write dropped, o_wfull falls.
- Mid-operation reset: with 5 words stored, assert i_rst_n=0 for one cycle → o_rempty=1, o_rdata=0; a subsequent write then read of 0x5A returns 0x5A.
